// File: rtl/skew_meter_pkg.sv
// rtl/skew_meter_pkg.sv - shared FSM state type and default sizing for the skew meter.
package skew_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/skew_meter_bit_sync.sv
// rtl/skew_meter_bit_sync.sv - multi-flop synchronizer for one asynchronous level.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/skew_meter.sv
// rtl/skew_meter.sv - measures edge counts, mismatch cycles and longest mismatch run
// between two looped-back asynchronous chain outputs over a programmable window.
module skew_meter
  import skew_meter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             start,
  input  logic [CNT_W-1:0] window,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edges_a,
  output logic [CNT_W-1:0] edges_b,
  output logic [CNT_W-1:0] mismatch,
  output logic [CNT_W-1:0] max_run,
  output logic             overflow
);

  logic sync_a, sync_b;
  logic prev_a_q, prev_b_q;

  (* keep_hierarchy = "yes" *)
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk_i(sys_clk), .rst_i(rst), .d_i(in_a), .q_o(sync_a)
  );

  (* keep_hierarchy = "yes" *)
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk_i(sys_clk), .rst_i(rst), .d_i(in_b), .q_o(sync_b)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      prev_a_q <= 1'b0;
      prev_b_q <= 1'b0;
    end else begin
      prev_a_q <= sync_a;
      prev_b_q <= sync_b;
    end
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] ea_q, ea_d, eb_q, eb_d, mm_q, mm_d, run_q, run_d, mr_q, mr_d;
  logic             ov_q, ov_d;
  logic [CNT_W-1:0] res_ea_q, res_ea_d, res_eb_q, res_eb_d;
  logic [CNT_W-1:0] res_mm_q, res_mm_d, res_mr_q, res_mr_d;
  logic             res_ov_q, res_ov_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    win_d    = win_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    mm_d     = mm_q;
    run_d    = run_q;
    mr_d     = mr_q;
    ov_d     = ov_q;
    res_ea_d = res_ea_q;
    res_eb_d = res_eb_q;
    res_mm_d = res_mm_q;
    res_mr_d = res_mr_q;
    res_ov_d = res_ov_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          win_d = window;
          cyc_d = '0;
          ea_d  = '0;
          eb_d  = '0;
          mm_d  = '0;
          run_d = '0;
          mr_d  = '0;
          ov_d  = 1'b0;
          if (window == '0) begin
            state_d  = ST_DONE;
            res_ea_d = '0;
            res_eb_d = '0;
            res_mm_d = '0;
            res_mr_d = '0;
            res_ov_d = 1'b0;
          end else begin
            state_d = ST_ARM;
          end
        end
      end

      ST_ARM: begin
        if (cyc_q == CNT_W'(SYNC_STAGES - 1)) begin
          cyc_d   = '0;
          state_d = ST_MEASURE;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end

      ST_MEASURE: begin
        if (sync_a && !prev_a_q) ea_d = sat_inc(ea_q);
        if (sync_b && !prev_b_q) eb_d = sat_inc(eb_q);
        if (sync_a != sync_b) begin
          mm_d  = sat_inc(mm_q);
          run_d = sat_inc(run_q);
        end else begin
          run_d = '0;
        end
        if (run_d > mr_q) mr_d = run_d;
        ov_d  = ov_q | (&ea_d) | (&eb_d) | (&mm_d) | (&run_d) | (&mr_d);
        cyc_d = cyc_q + CNT_W'(1);
        // Results capture the final cycle's contribution so they are valid during DONE.
        if (cyc_q == win_q - CNT_W'(1)) begin
          state_d  = ST_DONE;
          res_ea_d = ea_d;
          res_eb_d = eb_d;
          res_mm_d = mm_d;
          res_mr_d = mr_d;
          res_ov_d = ov_d;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      win_q    <= '0;
      ea_q     <= '0;
      eb_q     <= '0;
      mm_q     <= '0;
      run_q    <= '0;
      mr_q     <= '0;
      ov_q     <= 1'b0;
      res_ea_q <= '0;
      res_eb_q <= '0;
      res_mm_q <= '0;
      res_mr_q <= '0;
      res_ov_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      win_q    <= win_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      mm_q     <= mm_d;
      run_q    <= run_d;
      mr_q     <= mr_d;
      ov_q     <= ov_d;
      res_ea_q <= res_ea_d;
      res_eb_q <= res_eb_d;
      res_mm_q <= res_mm_d;
      res_mr_q <= res_mr_d;
      res_ov_q <= res_ov_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign edges_a  = res_ea_q;
  assign edges_b  = res_eb_q;
  assign mismatch = res_mm_q;
  assign max_run  = res_mr_q;
  assign overflow = res_ov_q;

endmodule
